btb_predictor: RTL and testbench

Parametrised branch-target buffer with saturating-counter direction prediction for the ThinPad pipeline. It supersedes the fixed single-behaviour BTB. IF uses it for a combinational next-PC prediction from the current PC. EXE uses it to resolve branches/jumps, which raises a mispredict flag with the corrected PC and trains a direct-mapped table. It also keeps saturating branch and mispredict statistics for debug LEDs.

---
 rtl/btb_predictor.sv | 131 +++++++++++++
 tb/tb_btb_predictor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor
//   Direct-mapped branch-target buffer with per-entry saturating direction
//   counters, plus saturating branch/mispredict statistics.
//
//   Ports
//     clk, rst           clock; asynchronous active-low reset
//     cur_pc             IF-stage PC (combinational lookup)
//     pred_taken/pred_pc prediction: hit with counter MSB set -> stored target,
//                        otherwise cur_pc+1
//     flush              synchronous invalidate of every entry
//     upd_*              EXE resolution of a branch/jump (trains the table)
//     mispredict/fix_pc  combinational resolution result
//     stat_branches      saturating count of upd_valid cycles
//     stat_mispred       saturating count of mispredict cycles
module btb_predictor #(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   cur_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_pc,
  input  logic              flush,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic [PC_W-1:0]   upd_pred_pc,
  output logic              mispredict,
  output logic [PC_W-1:0]   fix_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];

  logic [STAT_W-1:0]  stat_br_q, stat_br_d;
  logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;

  logic [IDX_W-1:0]   rd_idx, up_idx;
  logic [TAG_W-1:0]   rd_tag, up_tag;
  logic               rd_hit, up_hit;

  // Lookup: reads registered state only, so an update in the same cycle is
  // not visible until the following cycle.
  assign rd_idx     = cur_pc[IDX_W-1:0];
  assign rd_tag     = cur_pc[PC_W-1:IDX_W];
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken = rd_hit && cnt_q[rd_idx][CNT_W-1];
  assign pred_pc    = pred_taken ? target_q[rd_idx] : cur_pc + PC_W'(1);

  // Resolution
  assign up_idx     = upd_pc[IDX_W-1:0];
  assign up_tag     = upd_pc[PC_W-1:IDX_W];
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign fix_pc     = upd_taken ? upd_target : upd_pc + PC_W'(1);
  assign mispredict = upd_valid && (upd_pred_pc != fix_pc);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (cnt_q[up_idx] != CNT_MAX) cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
          target_d[up_idx] = upd_target;
        end else if (cnt_q[up_idx] != '0) begin
          cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Allocate, evicting whatever tag occupied the slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        cnt_d[up_idx]    = CNT_WEAK;
      end
    end
  end

  // Statistics keep counting even when flush suppresses the table write.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid && (stat_br_q != '1)) stat_br_d = stat_br_q + STAT_W'(1);
    if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

  logic        clk, rst;
  logic [15:0] cur_pc;
  logic        flush, upd_valid, upd_taken;
  logic [15:0] upd_pc, upd_target, upd_pred_pc;

  logic        pred_taken, mispredict;
  logic [15:0] pred_pc, fix_pc, stat_branches, stat_mispred;
  logic        s_pred_taken, s_mispredict;
  logic [15:0] s_pred_pc, s_fix_pc;
  logic [3:0]  s_stat_branches, s_stat_mispred;

  int checks = 0;
  int errors = 0;

  btb_predictor #(.PC_W(16), .ENTRIES(8), .CNT_W(2), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .cur_pc(cur_pc), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_pc(upd_pred_pc), .mispredict(mispredict),
    .fix_pc(fix_pc), .stat_branches(stat_branches), .stat_mispred(stat_mispred));

  btb_predictor #(.PC_W(16), .ENTRIES(8), .CNT_W(2), .STAT_W(4)) dut_s (
    .clk(clk), .rst(rst), .cur_pc(cur_pc), .pred_taken(s_pred_taken), .pred_pc(s_pred_pc),
    .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_pc(upd_pred_pc), .mispredict(s_mispredict),
    .fix_pc(s_fix_pc), .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer table, index = pc mod 8, tag = pc div 8.
  int m_valid [8];
  int m_tag   [8];
  int m_tgt   [8];
  int m_cnt   [8];
  int n_br, n_mp;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
    end
    n_br = 0; n_mp = 0;
  endfunction

  function automatic bit m_hit(int pc);
    return (m_valid[pc % 8] != 0) && (m_tag[pc % 8] == pc / 8);
  endfunction

  function automatic bit m_ptaken(int pc);
    return m_hit(pc) && (m_cnt[pc % 8] >= 2);
  endfunction

  function automatic logic [15:0] m_ppc(int pc);
    return m_ptaken(pc) ? 16'(m_tgt[pc % 8]) : 16'((pc + 1) % 65536);
  endfunction

  function automatic logic [15:0] m_fix();
    return upd_taken ? upd_target : 16'((int'(upd_pc) + 1) % 65536);
  endfunction

  function automatic bit m_misp();
    return upd_valid && (upd_pred_pc != m_fix());
  endfunction

  function automatic int sat(int n, int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic void m_commit();
    int pc, i;
    pc = int'(upd_pc);
    i  = pc % 8;
    if (upd_valid) begin
      n_br++;
      if (m_misp()) n_mp++;
    end
    if (flush) begin
      for (int k = 0; k < 8; k++) m_valid[k] = 0;
    end else if (upd_valid) begin
      if (m_hit(pc)) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = int'(upd_target);
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = pc / 8; m_tgt[i] = int'(upd_target); m_cnt[i] = 2;
      end
    end
  endfunction

  task automatic tick();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [15:0] pc, bit tk, logic [15:0] tgt, logic [15:0] ppc);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_pc = ppc;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 16'h0, 16'h0);
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); cur_pc = 16'h0010; m_reset();
    #3;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
    checks++;
    if (pred_pc !== 16'h0011) begin errors++; $display("FAIL reset_pred_pc got %h exp 0011", pred_pc); end
    checks++;
    if (stat_branches !== 16'h0 || stat_mispred !== 16'h0) begin
      errors++; $display("FAIL reset_stats got %h/%h exp 0/0", stat_branches, stat_mispred);
    end
    checks++;
    cur_pc = 16'hFFFF; #1;
    if (pred_pc !== 16'h0000) begin errors++; $display("FAIL reset_wrap got %h exp 0000", pred_pc); end
    checks++;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_allocate();
    drive(1, 16'h0012, 1, 16'h0040, 16'h0013); #1;
    if (mispredict !== 1'b1 || fix_pc !== 16'h0040) begin
      errors++; $display("FAIL alloc_resolve got misp=%0b fix=%h exp 1/0040", mispredict, fix_pc);
    end
    checks++;
    tick(); idle(); cur_pc = 16'h0012; #1;
    if (pred_taken !== 1'b1 || pred_pc !== 16'h0040) begin
      errors++; $display("FAIL alloc_lookup got %0b/%h exp 1/0040", pred_taken, pred_pc);
    end
    checks++;
    if (stat_mispred !== 16'd1 || stat_branches !== 16'd1) begin
      errors++; $display("FAIL alloc_stats got br=%0d mp=%0d exp 1/1", stat_branches, stat_mispred);
    end
    checks++;
  endtask

  task automatic test_hysteresis();
    cur_pc = 16'h0012;
    drive(1, 16'h0012, 0, 16'h0, m_ppc(16'h0012)); tick(); idle(); #1;
    if (pred_taken !== 1'b0 || pred_pc !== 16'h0013) begin
      errors++; $display("FAIL hyst_weak_nt got %0b/%h exp 0/0013", pred_taken, pred_pc);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0012, 1, 16'h0040, m_ppc(16'h0012)); tick();
    end
    idle();
    drive(1, 16'h0012, 0, 16'h0, m_ppc(16'h0012)); tick(); idle(); #1;
    if (pred_taken !== 1'b1 || pred_pc !== 16'h0040) begin
      errors++; $display("FAIL hyst_saturate got %0b/%h exp 1/0040", pred_taken, pred_pc);
    end
    checks++;
    drive(1, 16'h0012, 1, 16'h0040, 16'h0040); #1;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL hyst_correct got misp=%0b exp 0", mispredict); end
    checks++;
    tick(); idle();
    if (stat_branches !== 16'(n_br) || stat_mispred !== 16'(n_mp)) begin
      errors++; $display("FAIL hyst_stats got %0d/%0d exp %0d/%0d", stat_branches, stat_mispred, n_br, n_mp);
    end
    checks++;
  endtask

  task automatic test_alias();
    drive(1, 16'h001A, 1, 16'h0050, m_ppc(16'h001A)); tick(); idle();
    cur_pc = 16'h0012; #1;
    if (pred_taken !== 1'b0 || pred_pc !== 16'h0013) begin
      errors++; $display("FAIL alias_evicted got %0b/%h exp 0/0013", pred_taken, pred_pc);
    end
    checks++;
    cur_pc = 16'h001A; #1;
    if (pred_pc !== 16'h0050) begin errors++; $display("FAIL alias_new got %h exp 0050", pred_pc); end
    checks++;
    drive(1, 16'h0022, 0, 16'h0, m_ppc(16'h0022)); tick(); idle(); #1;
    if (pred_taken !== 1'b1 || pred_pc !== 16'h0050) begin
      errors++; $display("FAIL alias_nt_miss got %0b/%h exp 1/0050", pred_taken, pred_pc);
    end
    checks++;
  endtask

  task automatic test_flush();
    logic [15:0] pcs [3];
    pcs[0] = 16'h001A; pcs[1] = 16'h0033; pcs[2] = 16'h0012;
    flush = 1; drive(1, 16'h0033, 1, 16'h0077, 16'h0034); tick(); idle();
    foreach (pcs[k]) begin
      cur_pc = pcs[k]; #1;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL flush_lookup pc=%h got %0b exp 0", pcs[k], pred_taken); end
      checks++;
    end
    if (stat_branches !== 16'(n_br)) begin
      errors++; $display("FAIL flush_stat got %0d exp %0d", stat_branches, n_br);
    end
    checks++;
    // Rebuild an entry, then reset asynchronously in the middle of an update.
    drive(1, 16'h0044, 1, 16'h0123, 16'h0045); tick(); idle();
    cur_pc = 16'h0044;
    drive(1, 16'h0044, 1, 16'h0321, 16'h0123); #2;
    rst = 0; m_reset(); #1;
    if (pred_taken !== 1'b0 || pred_pc !== 16'h0045 || stat_branches !== 16'h0 || stat_mispred !== 16'h0) begin
      errors++; $display("FAIL async_reset got %0b/%h br=%0d mp=%0d exp 0/0045/0/0", pred_taken, pred_pc, stat_branches, stat_mispred);
    end
    checks++;
    @(posedge clk); #1; idle(); rst = 1;
    @(posedge clk); #1;
    if (pred_taken !== 1'b0 || stat_branches !== 16'h0) begin
      errors++; $display("FAIL reset_discard got %0b br=%0d exp 0/0", pred_taken, stat_branches);
    end
    checks++;
  endtask

  task automatic test_saturation();
    logic [15:0] pc;
    for (int k = 0; k < 20; k++) begin
      pc = 16'($urandom_range(0, 255));
      drive(1, pc, 1, 16'($urandom), 16'h0);
      upd_pred_pc = m_fix() ^ 16'h0001;
      tick();
    end
    idle();
    if (s_stat_branches !== 4'hF || s_stat_mispred !== 4'hF) begin
      errors++; $display("FAIL sat4_stats got %h/%h exp F/F", s_stat_branches, s_stat_mispred);
    end
    checks++;
    if (stat_branches !== 16'd20 || stat_mispred !== 16'd20) begin
      errors++; $display("FAIL sat16_stats got %0d/%0d exp 20/20", stat_branches, stat_mispred);
    end
    checks++;
    drive(1, 16'h0001, 0, 16'h0, 16'h0009); tick(); idle();
    if (s_stat_branches !== 4'hF || s_stat_mispred !== 4'hF) begin
      errors++; $display("FAIL sat4_hold got %h/%h exp F/F", s_stat_branches, s_stat_mispred);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      flush = ($urandom_range(0, 24) == 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            16'($urandom), 16'h0);
      if ($urandom_range(0, 15) == 0) upd_pc = 16'hFFFF;
      upd_pred_pc = ($urandom_range(0, 2) != 0) ? m_ppc(int'(upd_pc)) : 16'($urandom);
      cur_pc = ($urandom_range(0, 3) == 0) ? upd_pc : 16'($urandom_range(0, 31));
      #1;
      if (pred_taken !== m_ptaken(int'(cur_pc)) || pred_pc !== m_ppc(int'(cur_pc))) begin
        errors++; $display("FAIL rand_pred pc=%h got %0b/%h exp %0b/%h", cur_pc, pred_taken, pred_pc,
                           m_ptaken(int'(cur_pc)), m_ppc(int'(cur_pc)));
      end
      checks++;
      if (mispredict !== m_misp() || fix_pc !== m_fix()) begin
        errors++; $display("FAIL rand_resolve got %0b/%h exp %0b/%h", mispredict, fix_pc, m_misp(), m_fix());
      end
      checks++;
      tick();
      if (stat_branches !== 16'(sat(n_br, 65535)) || stat_mispred !== 16'(sat(n_mp, 65535)) ||
          s_stat_branches !== 4'(sat(n_br, 15)) || s_stat_mispred !== 4'(sat(n_mp, 15))) begin
        errors++; $display("FAIL rand_stats got %0d/%0d %0d/%0d exp %0d/%0d", stat_branches, stat_mispred,
                           s_stat_branches, s_stat_mispred, n_br, n_mp);
      end
      checks++;
    end
    idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 0; m_reset();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_flush();
    pulse_reset();
    test_saturation();
    pulse_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
